// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - Program-memory and observation bus of the accumulator core.
interface cpu_if;
    logic [7:0] inst;
    logic       Y;
    logic [3:0] PC;
    logic [3:0] MAR;
    logic [7:0] MBR;
    logic [7:0] signal;

    modport master (input inst, output Y, PC, MAR, MBR, signal);
    modport slave  (output inst, input Y, PC, MAR, MBR, signal);
endinterface

// File: rtl/cpu.sv
// rtl/cpu.sv - 8-bit accumulator core, five-state multicycle sequence, 16x8 data RAM.
// Optional carry flag and conditional JC enabled by defining CPU_CARRY_EN.
module cpu (
    input  logic  clk,
    input  logic  reset,
    cpu_if.master bus
);
    typedef enum logic [5:0] {
        S_F1   = 6'b000001,
        S_F2   = 6'b000010,
        S_DEC  = 6'b000100,
        S_MEM  = 6'b001000,
        S_EXE  = 6'b010000,
        S_HALT = 6'b100000
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] mbr_q, mbr_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic       z_q, z_d;
    logic [7:0] ram_q [16];
    logic       ram_we;
    logic       a_wr;
    logic       c_wr;
    logic [8:0] res;
`ifdef CPU_CARRY_EN
    logic       c_q, c_d;
`else
    logic       unused_carry;
    assign unused_carry = res[8] ^ c_wr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_F1;
            pc_q    <= '0;
            mar_q   <= '0;
            mbr_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            z_q     <= 1'b0;
`ifdef CPU_CARRY_EN
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            z_q     <= z_d;
`ifdef CPU_CARRY_EN
            c_q     <= c_d;
`endif
        end
    end

    // STA writes the operand address straight from IR, so a following LDA sees it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) ram_q[i] <= '0;
        end else if (ram_we) begin
            ram_q[ir_q[3:0]] <= a_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        ir_d    = ir_q;
        a_d     = a_q;
        z_d     = z_q;
`ifdef CPU_CARRY_EN
        c_d     = c_q;
`endif
        ram_we  = 1'b0;
        a_wr    = 1'b0;
        c_wr    = 1'b0;
        res     = '0;
        case (state_q)
            S_F1: begin
                mar_d   = pc_q;
                state_d = S_F2;
            end
            S_F2: begin
                ir_d    = bus.inst;
                mbr_d   = bus.inst;
                pc_d    = pc_q + 4'd1;
                state_d = S_DEC;
            end
            S_DEC: begin
                mar_d   = ir_q[3:0];
                state_d = S_MEM;
            end
            S_MEM: begin
                mbr_d   = ram_q[mar_q];
                state_d = S_EXE;
            end
            S_EXE: begin
                state_d = S_F1;
                case (ir_q[7:4])
                    4'h1: begin res = {1'b0, mbr_q};                a_wr = 1'b1; end
                    4'h2: begin ram_we = 1'b1; mbr_d = a_q;                      end
                    4'h3: begin res = {1'b0, a_q} + {1'b0, mbr_q};  a_wr = 1'b1; c_wr = 1'b1; end
                    4'h4: begin res = {1'b0, a_q} - {1'b0, mbr_q};  a_wr = 1'b1; c_wr = 1'b1; end
                    4'h5: begin res = {1'b0, a_q & mbr_q};          a_wr = 1'b1; end
                    4'h6: begin res = {1'b0, a_q | mbr_q};          a_wr = 1'b1; end
                    4'h7: begin res = {1'b0, a_q ^ mbr_q};          a_wr = 1'b1; end
                    4'h8: begin res = {5'b0, ir_q[3:0]};            a_wr = 1'b1; end
                    4'h9: pc_d = ir_q[3:0];
                    4'hA: if (z_q) pc_d = ir_q[3:0];
`ifdef CPU_CARRY_EN
                    4'hB: if (c_q) pc_d = ir_q[3:0];
`endif
                    4'hC: begin res = {1'b0, ~a_q};                 a_wr = 1'b1; end
                    4'hD: begin res = {1'b0, a_q} + 9'd1;           a_wr = 1'b1; c_wr = 1'b1; end
                    4'hE: begin res = {1'b0, a_q} - 9'd1;           a_wr = 1'b1; c_wr = 1'b1; end
                    4'hF: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_F1;
        endcase
        // Borrow of a 9-bit subtraction lands in res[8], same as carry of an add.
        if (a_wr) begin
            a_d   = res[7:0];
            z_d   = (res[7:0] == 8'd0);
            mbr_d = res[7:0];
        end
`ifdef CPU_CARRY_EN
        if (c_wr) c_d = res[8];
`endif
    end

    assign bus.Y   = (state_q == S_HALT);
    assign bus.PC  = pc_q;
    assign bus.MAR = mar_q;
    assign bus.MBR = mbr_q;
`ifdef CPU_CARRY_EN
    assign bus.signal = {c_q, z_q, state_q};
`else
    assign bus.signal = {1'b0, z_q, state_q};
`endif
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - Self-checking bench for cpu against an instruction-level model.
module tb_cpu;
`ifdef CPU_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_if bus ();
    cpu dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [3:0] m_pc, m_mar;
    logic [7:0] m_mbr, m_a;
    logic       m_z, m_c, m_halt;
    logic [7:0] m_ram [16];
    int         m_phase;
    bit         chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_sig();
        logic [7:0] s;
        s = 8'd0;
        s[m_phase] = 1'b1;
        s[6] = m_z;
        s[7] = CARRY ? m_c : 1'b0;
        return s;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("Y", bus.Y, m_halt);
            chk("PC", bus.PC, m_pc);
            chk("MAR", bus.MAR, m_mar);
            chk("MBR", bus.MBR, m_mbr);
            chk("signal", bus.signal, exp_sig());
        end
    end

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_mbr = 0; m_a = 0;
        m_z = 0; m_c = 0; m_halt = 0; m_phase = 0;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_PC", bus.PC, 4'd0);
        chk("rst_signal", bus.signal, 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one instruction, from the opcode table.
    task automatic exe(input logic [3:0] op, input logic [3:0] k);
        logic [8:0] t;
        bit wa;
        wa = 0;
        case (op)
            4'h1: begin m_a = m_mbr; wa = 1; end
            4'h2: begin m_ram[k] = m_a; m_mbr = m_a; end
            4'h3: begin t = m_a + m_mbr; if (CARRY) m_c = (t > 255); m_a = t[7:0]; wa = 1; end
            4'h4: begin if (CARRY) m_c = (m_a < m_mbr); m_a = m_a - m_mbr; wa = 1; end
            4'h5: begin m_a = m_a & m_mbr; wa = 1; end
            4'h6: begin m_a = m_a | m_mbr; wa = 1; end
            4'h7: begin m_a = m_a ^ m_mbr; wa = 1; end
            4'h8: begin m_a = {4'd0, k}; wa = 1; end
            4'h9: m_pc = k;
            4'hA: if (m_z) m_pc = k;
            4'hB: if (CARRY && m_c) m_pc = k;
            4'hC: begin m_a = ~m_a; wa = 1; end
            4'hD: begin if (CARRY) m_c = (m_a == 8'hFF); m_a = m_a + 8'd1; wa = 1; end
            4'hE: begin if (CARRY) m_c = (m_a == 8'h00); m_a = m_a - 8'd1; wa = 1; end
            4'hF: m_halt = 1;
            default: ;
        endcase
        if (wa) begin
            m_z = (m_a == 8'd0);
            m_mbr = m_a;
        end
    endtask

    task automatic run(input logic [7:0] ins);
        bus.inst = ins;
        step(); m_mar = m_pc; m_phase = 1;
        step(); m_mbr = ins; m_pc = m_pc + 4'd1; m_phase = 2;
        bus.inst = 8'($urandom);
        step(); m_mar = ins[3:0]; m_phase = 3;
        step(); m_mbr = m_ram[ins[3:0]]; m_phase = 4;
        step(); exe(ins[7:4], ins[3:0]); m_phase = m_halt ? 5 : 0;
    endtask

    initial begin
        bus.inst = 8'h01;
        model_reset();

        // Reset and first instruction walk
        do_reset();
        run(8'h01);
        chk("nop_PC", bus.PC, 4'd1);
        chk("nop_signal", bus.signal, 8'h01);

        // Immediate load, store, add, store/load forwarding
        do_reset();
        run(8'h85);
        chk("ldi_MBR", bus.MBR, 8'h05);
        run(8'h23);
        chk("sta_model_ram3", m_ram[3], 8'h05);
        run(8'h33);
        chk("add_MBR", bus.MBR, 8'h0A);
        chk("add_Z", bus.signal[6], 1'b0);
        chk("add_C", bus.signal[7], 1'b0);
        chk("add_PC", bus.PC, 4'd3);
        run(8'h24);
        run(8'h14);
        chk("sta_lda_MBR", bus.MBR, 8'h0A);

        // Carry and zero, conditional jumps, ALU sweep
        do_reset();
        run(8'h8F);
        run(8'hC0);
        chk("not_MBR", bus.MBR, 8'hF0);
        repeat (16) run(8'hD0);
        chk("inc_wrap_MBR", bus.MBR, 8'h00);
        chk("inc_wrap_Z", bus.signal[6], 1'b1);
        chk("inc_wrap_C", bus.signal[7], CARRY);
        run(8'hB9);
        chk("jc_PC", bus.PC, CARRY ? 4'd9 : 4'd3);
        run(8'h81);
        run(8'hA5);
        chk("jz_not_taken_PC", bus.PC, CARRY ? 4'd11 : 4'd5);
        run(8'h80);
        run(8'hA6);
        chk("jz_taken_PC", bus.PC, 4'd6);
        run(8'h82); run(8'h20); run(8'h81); run(8'h40);
        chk("sub_borrow_MBR", bus.MBR, 8'hFF);
        chk("sub_borrow_C", bus.signal[7], CARRY);
        run(8'h50);
        chk("and_MBR", bus.MBR, 8'h02);
        run(8'h60); run(8'h8C); run(8'h70);
        chk("xor_MBR", bus.MBR, 8'h0E);
        run(8'hE0); run(8'h80); run(8'hE0);
        chk("dec_wrap_MBR", bus.MBR, 8'hFF);
        run(8'h30);
        chk("add_carry_MBR", bus.MBR, 8'h01);

        // Unconditional jump
        do_reset();
        run(8'h97);
        chk("jmp_PC", bus.PC, 4'd7);
        run(8'h01);

        // PC wrap
        do_reset();
        repeat (16) run(8'h01);
        chk("wrap_PC", bus.PC, 4'd0);

        // Halt, then asynchronous reset while halted
        do_reset();
        run(8'h83);
        run(8'hF0);
        chk("hlt_Y", bus.Y, 1'b1);
        chk("hlt_signal", bus.signal, 8'h20);
        repeat (12) step();
        chk("hlt_PC_frozen", bus.PC, 4'd2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_Y", bus.Y, 1'b0);
        chk("async_rst_PC", bus.PC, 4'd0);
        chk("async_rst_signal", bus.signal, 8'h01);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        run(8'h01);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu.md
# cpu

Minimal 8-bit accumulator processor core with a 4-bit program counter and a 16×8 internal data RAM. Instructions arrive on the `inst` bus from an external program memory addressed by `PC`. The core runs a fixed five-state multicycle sequence per instruction and exposes its architectural registers and one-hot control state for observation.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inst`  in  8  instruction word at program address `PC`; `[7:4]` is the opcode, `[3:0]` is the operand (address or immediate).
- `Y`  out  1  halt indicator; 1 once HLT has executed.
- `PC`  out  4  program counter.
- `MAR`  out  4  memory address register.
- `MBR`  out  8  memory buffer register.
- `signal`  out  8  `[5:0]` one-hot state (F1, F2, DEC, MEM, EXE, HALT); `[6]` zero flag Z; `[7]` carry flag C.

## Operation
- Internal state: accumulator A[7:0], IR[7:0], flags Z and C, and RAM[0..15] of 8 bits each.
- On reset, all registers and all RAM words clear to 0, and the state is F1.
  - Reset outputs: `Y`=0, `PC`=0, `MAR`=0, `MBR`=0, `signal`=8'h01.
- State sequence: F1→F2→DEC→MEM→EXE, then back to F1. HLT transitions to HALT instead.
  - F1: MAR←PC.
  - F2: IR←inst; MBR←inst; PC←PC+1 (modulo 16, so 15 wraps to 0).
  - DEC: MAR←IR[3:0].
  - MEM: MBR←RAM[MAR].
  - EXE: execute IR as listed below.
- HALT: all registers hold, `Y`=1. Only reset exits HALT.
- Opcodes (m = MBR read in MEM, k = IR[3:0]):
  - 0 NOP
  - 1 LDA: A←m
  - 2 STA: RAM[k]←A
  - 3 ADD: {C,A}←A+m
  - 4 SUB: {C,A}←A−m, where C=1 means borrow
  - 5 AND
  - 6 OR
  - 7 XOR
  - 8 LDI: A←{4'b0,k}
  - 9 JMP: PC←k
  - A JZ: if Z, PC←k
  - B JC: if C, PC←k
  - C NOT: A←~A
  - D INC: {C,A}←A+1
  - E DEC: {C,A}←A−1
  - F HLT
- Flag updates:
  - Z←(new A==0) for opcodes 1, 3–8, C–E. Z is otherwise unchanged.
  - C is written only by ADD, SUB, INC and DEC.
- MBR in EXE:
  - Opcodes that write A also set MBR←new A.
  - STA sets MBR←A.
  - All other opcodes leave MBR unchanged.
- Arithmetic is 8-bit unsigned and wraps. For example, 8'hFF+1 gives A=0, C=1, Z=1.
- STA followed immediately by LDA of the same address returns the stored value, because the write completes in EXE.

## Timing
- Each instruction takes exactly 5 clocks, including jumps and NOP.
- `inst` is sampled only at the F2 edge. It must be stable for setup/hold around that edge and is don't-care in all other states.
- A jump target becomes visible on `PC` one cycle after the EXE edge, and is loaded into MAR in the following F1.
- Asserting reset at any time, including mid-instruction or in HALT, immediately forces the reset values.
- Outputs are registered, with no combinational path from `inst`.

## Configuration
- `CPU_CARRY_EN`:
  - Defined: the carry flag C exists, ADD/SUB/INC/DEC update it, JC is a conditional jump, and `signal[7]`=C.
  - Undefined: C is removed, JC executes as NOP, `signal[7]` is tied 0, and arithmetic still wraps at 8 bits.

## Test plan
- Reset: hold `reset`=0 for 2 clocks with `inst`=8'h01, then release. Expect PC=0, MAR=0, MBR=0, Y=0 and signal=8'h01 during reset; after release PC=1 following the first F2 and `signal` walks 01→02→04→08→10→01.
- Immediate load and add:
  - Program 0x85 (LDI 5), 0x23 (STA 3), 0x33 (ADD 3).
  - After LDI: MBR=8'h05.
  - After STA: RAM[3]=5.
  - After ADD: MBR=8'h0A, Z=0, C=0, PC=3.
- Carry and zero:
  - Program 0x8F (LDI 15) followed by 0xC0 (NOT): expect MBR=8'hF0.
  - Then 0xD0 (INC) repeated 16 times: on the last one, A=0, `signal[6]`=1, `signal[7]`=1.
- Jumps:
  - `inst`=0x97 (JMP 7): expect PC=7 before the next F1.
  - JZ with Z=0: expect PC incremented only.
  - JC with C=1: expect the branch is taken.
- PC wrap: 16 NOPs (0x01) from reset. Expect PC to return to 0 after the 16th F2.
- Halt and reset mid-halt:
  - `inst`=8'hF0: expect Y=1, `signal`[5]=1, and PC frozen for 10 or more clocks.
  - Pulse `reset`=0 asynchronously between edges: expect Y=0 and PC=0 immediately.
